alarmclockhdl_mm_copy_master: RTL and testbench

//  Avalon-MM master that copies LEN 32-bit words from SRC to DST (e.g. alarm/time snapshot into on-chip RAM).

---
 rtl/alarmclockhdl_mm_pkg.sv | 15 +
 rtl/alarmclockhdl_mm_copy_master.sv | 166 ++++++++++++++++
 tb/tb_alarmclockhdl_mm_copy_master.sv | 397 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alarmclockhdl_mm_pkg.sv
// Shared types and constants for the Avalon-MM word copy master.
package alarmclockhdl_mm_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_REQ,
    FINISH
  } state_t;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam logic [3:0]  BE_ALL         = 4'hF;

endpackage

// File: rtl/alarmclockhdl_mm_copy_master.sv
// Avalon-MM master copying len 32-bit words from src_addr to dst_addr, one word
// at a time (read, wait for data, write), with misalignment and read-timeout abort.
module alarmclockhdl_mm_copy_master
  import alarmclockhdl_mm_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned LEN_W   = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [LEN_W-1:0]  words_done,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  output logic [3:0]        avm_byteenable,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_readdatavalid,
  input  logic              avm_waitrequest,
  output state_t            dbg_state
);

  localparam int unsigned       WAIT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(BYTES_PER_WORD);

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_cur_src;
  logic [ADDR_W-1:0]   r_cur_dst;
  logic [LEN_W-1:0]    r_len;
  logic [LEN_W-1:0]    r_words_done;
  logic [31:0]         r_buf;
  logic [WAIT_W-1:0]   r_wait_cnt;
  logic                r_error;

  logic                w_misalign;
  logic [LEN_W-1:0]    w_words_inc;
  logic                w_accept_start;
  logic                w_capture;
  logic                w_wr_accept;
  logic                w_wait_clr;
  logic                w_wait_inc;
  logic                w_timeout;

  assign w_misalign  = |{src_addr[1:0], dst_addr[1:0]};
  assign w_words_inc = r_words_done + 1'b1;

  assign error      = r_error;
  assign words_done = r_words_done;
  assign dbg_state  = r_state;

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Bus handshake: a request (read or write with address/data) is held unchanged
  // while waitrequest is high and completes on the first cycle it is low.
  always_comb begin
    w_next         = r_state;
    w_accept_start = 1'b0;
    w_capture      = 1'b0;
    w_wr_accept    = 1'b0;
    w_wait_clr     = 1'b0;
    w_wait_inc     = 1'b0;
    w_timeout      = 1'b0;
    busy           = 1'b0;
    done           = 1'b0;
    avm_read       = 1'b0;
    avm_write      = 1'b0;
    avm_address    = '0;
    avm_writedata  = '0;
    avm_byteenable = '0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept_start = 1'b1;
          w_next         = (w_misalign || len == '0) ? FINISH : RD_REQ;
        end
      end
      RD_REQ: begin
        busy           = 1'b1;
        avm_read       = 1'b1;
        avm_address    = r_cur_src;
        avm_byteenable = BE_ALL;
        if (!avm_waitrequest) begin
          if (avm_readdatavalid) begin
            w_capture = 1'b1;
            w_next    = WR_REQ;
          end else begin
            w_wait_clr = 1'b1;
            w_next     = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        busy = 1'b1;
        if (avm_readdatavalid) begin
          w_capture = 1'b1;
          w_next    = WR_REQ;
        end else if (TIMEOUT != 0 && r_wait_cnt == WAIT_LAST) begin
          w_timeout = 1'b1;
          w_next    = FINISH;
        end else begin
          w_wait_inc = 1'b1;
        end
      end
      WR_REQ: begin
        busy           = 1'b1;
        avm_write      = 1'b1;
        avm_address    = r_cur_dst;
        avm_writedata  = r_buf;
        avm_byteenable = BE_ALL;
        if (!avm_waitrequest) begin
          w_wr_accept = 1'b1;
          w_next      = (w_words_inc == r_len) ? FINISH : RD_REQ;
        end
      end
      FINISH: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cur_src    <= '0;
      r_cur_dst    <= '0;
      r_len        <= '0;
      r_words_done <= '0;
      r_buf        <= '0;
      r_wait_cnt   <= '0;
      r_error      <= 1'b0;
    end else begin
      if (w_accept_start) begin
        r_cur_src    <= src_addr;
        r_cur_dst    <= dst_addr;
        r_len        <= len;
        r_words_done <= '0;
        r_error      <= w_misalign;
      end
      if (w_capture) r_buf <= avm_readdata;
      if (w_wait_clr)      r_wait_cnt <= '0;
      else if (w_wait_inc) r_wait_cnt <= r_wait_cnt + 1'b1;
      if (w_timeout) r_error <= 1'b1;
      // Addresses wrap silently at the top of the address space.
      if (w_wr_accept) begin
        r_cur_src    <= r_cur_src + ADDR_STEP;
        r_cur_dst    <= r_cur_dst + ADDR_STEP;
        r_words_done <= w_words_inc;
      end
    end
  end

endmodule

// File: tb/tb_alarmclockhdl_mm_copy_master.sv
// Directed bench for the copy master: an Avalon RAM slave model with optional
// random stalls and read latency, plus one task per scenario.
module tb_alarmclockhdl_mm_copy_master;
  import alarmclockhdl_mm_pkg::*;

  localparam int unsigned TO  = 8;
  localparam logic [31:0] PAT = 32'hA500_0000;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] src_addr = '0;
  logic [31:0] dst_addr = '0;
  logic [15:0] len = '0;
  logic        busy, done, error;
  logic [15:0] words_done;
  logic [31:0] avm_address;
  logic        avm_read, avm_write;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_readdata = '0;
  logic        avm_readdatavalid = 1'b0;
  logic        avm_waitrequest = 1'b0;
  state_t      dbg_state;

  always #5 clk = ~clk;

  alarmclockhdl_mm_copy_master #(.ADDR_W(32), .LEN_W(16), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
    .busy(busy), .done(done), .error(error), .words_done(words_done),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
    .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
    .avm_waitrequest(avm_waitrequest), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard / slave state ----------------
  int          vectors = 0;
  int          miscompares = 0;
  bit          wait_en = 1'b0;
  bit          no_resp = 1'b0;
  int          lat_max = 1;
  bit          rsp_pend = 1'b0;
  int          rsp_cnt = 0;
  logic [31:0] rsp_data = '0;
  bit          prev_stall = 1'b0;
  logic [65:0] prev_req = '0;
  int          rd_cycles = 0;
  int          wr_cycles = 0;
  logic [31:0] mem [0:1023];
  logic [31:0] exp_q[$];
  logic [31:0] exp_addr_q[$];

  // RAM slave: acts on the falling edge, DUT bus outputs are state-decoded.
  task automatic slave_loop();
    logic [65:0] cur_req;
    logic [31:0] ed, ea;
    logic [3:0]  exp_be;
    forever begin
      @(negedge clk);
      avm_readdatavalid = 1'b0;
      avm_readdata      = 32'hDEAD_BEEF;
      if (rsp_pend) begin
        rsp_cnt--;
        if (rsp_cnt == 0) begin
          avm_readdatavalid = 1'b1;
          avm_readdata      = rsp_data;
          rsp_pend          = 1'b0;
        end
      end
      if (reset) begin
        rsp_pend        = 1'b0;
        prev_stall      = 1'b0;
        avm_waitrequest = 1'b0;
      end else begin
        cur_req = {avm_read, avm_write, avm_address, avm_writedata};
        if (avm_read)  rd_cycles++;
        if (avm_write) wr_cycles++;
        if (prev_stall) begin
          vectors++;
          if (cur_req !== prev_req) begin
            miscompares++;
            $display("FAIL stall_hold: got %h exp %h", cur_req, prev_req);
          end
        end
        exp_be = (avm_read || avm_write) ? 4'hF : 4'h0;
        vectors++;
        if (avm_byteenable !== exp_be || (avm_read && avm_write)) begin
          miscompares++;
          $display("FAIL bus_ctrl: got rd=%b wr=%b be=%h exp be=%h no overlap",
                   avm_read, avm_write, avm_byteenable, exp_be);
        end
        avm_waitrequest = (avm_read || avm_write) && wait_en && ($urandom_range(1, 0) == 1);
        prev_stall = (avm_read || avm_write) && avm_waitrequest;
        prev_req   = cur_req;
        if (avm_read && !avm_waitrequest && !no_resp) begin
          rsp_pend = 1'b1;
          rsp_cnt  = $urandom_range(lat_max, 1);
          rsp_data = mem[avm_address[11:2]];
        end
        if (avm_write && !avm_waitrequest) begin
          mem[avm_address[11:2]] = avm_writedata;
          vectors++;
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL sb_extra_write: got addr %h data %h exp no write",
                     avm_address, avm_writedata);
          end else begin
            ed = exp_q.pop_front();
            ea = exp_addr_q.pop_front();
            if ({avm_address, avm_writedata} !== {ea, ed}) begin
              miscompares++;
              $display("FAIL sb_write: got addr %h data %h exp addr %h data %h",
                       avm_address, avm_writedata, ea, ed);
            end
          end
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic prime(input logic [31:0] s, input logic [31:0] d, input int n);
    logic [31:0] sa, da;
    exp_q.delete();
    exp_addr_q.delete();
    for (int i = 0; i < n; i++) begin
      sa = s + 32'(4 * i);
      da = d + 32'(4 * i);
      mem[sa[11:2]] = PAT ^ sa;
      mem[da[11:2]] = 32'h0;
      exp_q.push_back(PAT ^ sa);
      exp_addr_q.push_back(da);
    end
  endtask

  task automatic do_start(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
    @(negedge clk);
    src_addr  = s;
    dst_addr  = d;
    len       = n;
    start     = 1'b1;
    rd_cycles = 0;
    wr_cycles = 0;
  endtask

  // k = falling edges after the one that drove start; -1 if done never came.
  task automatic wait_done(input int max_cyc, output int k, output logic err,
                           output logic [15:0] wd, output logic fb, output logic bd);
    k = 0; err = 1'bx; wd = 'x; fb = 1'bx; bd = 1'bx;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      start = 1'b0;
      k++;
      if (k == 1) fb = busy;
      if (done === 1'b1) begin
        err = error; wd = words_done; bd = busy;
        return;
      end
    end
    k = -1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    vectors++;
    if ({busy, done, error, avm_read, avm_write} !== 5'b0) begin
      miscompares++;
      $display("FAIL rst_flags: got %b exp 00000", {busy, done, error, avm_read, avm_write});
    end
    vectors++;
    if (words_done !== 16'h0) begin
      miscompares++; $display("FAIL rst_words: got %0d exp 0", words_done);
    end
    vectors++;
    if ({avm_address, avm_writedata, avm_byteenable} !== 68'h0) begin
      miscompares++;
      $display("FAIL rst_bus: got %h %h %h exp 0", avm_address, avm_writedata, avm_byteenable);
    end
    vectors++;
    if (dbg_state !== IDLE) begin
      miscompares++; $display("FAIL rst_state: got %0d exp %0d", dbg_state, IDLE);
    end
  endtask

  task automatic test_copy_basic();
    int k; logic e, fb, bd; logic [15:0] wd; logic [31:0] a;
    prime(32'h0000, 32'h0100, 4);
    do_start(32'h0000, 32'h0100, 16'd4);
    wait_done(60, k, e, wd, fb, bd);
    // first RD_REQ is edge 1; four 3-cycle words end at edge 12, FINISH at 13
    vectors++;
    if (k !== 13) begin miscompares++; $display("FAIL basic_latency: got %0d exp 13", k); end
    vectors++;
    if ({e, fb, bd} !== 3'b010) begin
      miscompares++; $display("FAIL basic_flags: got err/busy1/busy_done %b exp 010", {e, fb, bd});
    end
    vectors++;
    if (wd !== 16'd4) begin miscompares++; $display("FAIL basic_words: got %0d exp 4", wd); end
    vectors++;
    if (rd_cycles !== 4 || wr_cycles !== 4) begin
      miscompares++; $display("FAIL basic_beats: got rd %0d wr %0d exp 4 4", rd_cycles, wr_cycles);
    end
    for (int i = 0; i < 4; i++) begin
      a = 32'h0100 + 32'(4 * i);
      vectors++;
      if (mem[a[11:2]] !== (PAT ^ 32'(4 * i))) begin
        miscompares++;
        $display("FAIL basic_mem%0d: got %h exp %h", i, mem[a[11:2]], PAT ^ 32'(4 * i));
      end
    end
  endtask

  task automatic test_random_stall();
    int k; logic e, fb, bd; logic [15:0] wd; logic [31:0] a;
    wait_en = 1'b1;
    lat_max = 5;
    prime(32'h0200, 32'h0300, 6);
    do_start(32'h0200, 32'h0300, 16'd6);
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    // a second start while busy must be dropped
    src_addr = 32'h0800; dst_addr = 32'h0900; len = 16'd1; start = 1'b1;
    wait_done(600, k, e, wd, fb, bd);
    vectors++;
    if (k <= 0) begin miscompares++; $display("FAIL rand_done: got %0d exp >0", k); end
    vectors++;
    if (e !== 1'b0 || wd !== 16'd6) begin
      miscompares++; $display("FAIL rand_result: got err %b words %0d exp 0 6", e, wd);
    end
    vectors++;
    if (exp_q.size() !== 0) begin
      miscompares++; $display("FAIL rand_sb_left: got %0d exp 0", exp_q.size());
    end
    for (int i = 0; i < 6; i++) begin
      a = 32'h0300 + 32'(4 * i);
      vectors++;
      if (mem[a[11:2]] !== (PAT ^ (32'h0200 + 32'(4 * i)))) begin
        miscompares++;
        $display("FAIL rand_mem%0d: got %h exp %h", i, mem[a[11:2]], PAT ^ (32'h0200 + 32'(4 * i)));
      end
    end
    wait_en = 1'b0;
    lat_max = 1;
  endtask

  task automatic test_misalign();
    int k; logic e, fb, bd; logic [15:0] wd;
    exp_q.delete(); exp_addr_q.delete();
    do_start(32'h0002, 32'h0100, 16'd3);
    wait_done(20, k, e, wd, fb, bd);
    vectors++;
    if (k !== 1 || e !== 1'b1) begin
      miscompares++; $display("FAIL mis_done: got k %0d err %b exp 1 1", k, e);
    end
    vectors++;
    if (wd !== 16'd0 || bd !== 1'b0) begin
      miscompares++; $display("FAIL mis_words: got %0d busy %b exp 0 0", wd, bd);
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (rd_cycles !== 0 || wr_cycles !== 0) begin
      miscompares++; $display("FAIL mis_bus: got rd %0d wr %0d exp 0 0", rd_cycles, wr_cycles);
    end
    vectors++;
    if (error !== 1'b1) begin miscompares++; $display("FAIL mis_err_hold: got %b exp 1", error); end
  endtask

  task automatic test_len_zero();
    int k; logic e, fb, bd; logic [15:0] wd;
    exp_q.delete(); exp_addr_q.delete();
    do_start(32'h0000, 32'h0100, 16'd0);
    wait_done(20, k, e, wd, fb, bd);
    vectors++;
    if (k !== 1 || e !== 1'b0) begin
      miscompares++; $display("FAIL len0_done: got k %0d err %b exp 1 0", k, e);
    end
    vectors++;
    if (wd !== 16'd0 || fb !== 1'b0) begin
      miscompares++; $display("FAIL len0_words: got %0d busy %b exp 0 0", wd, fb);
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (rd_cycles !== 0 || wr_cycles !== 0) begin
      miscompares++; $display("FAIL len0_bus: got rd %0d wr %0d exp 0 0", rd_cycles, wr_cycles);
    end
  endtask

  task automatic test_timeout();
    int k; logic e, fb, bd; logic [15:0] wd;
    no_resp = 1'b1;
    prime(32'h0000, 32'h0100, 2);
    do_start(32'h0000, 32'h0100, 16'd2);
    wait_done(40, k, e, wd, fb, bd);
    // RD_REQ at edge 1, eight RD_WAIT cycles at edges 2..9, FINISH at 10
    vectors++;
    if (k !== 10) begin miscompares++; $display("FAIL to_latency: got %0d exp 10", k); end
    vectors++;
    if (e !== 1'b1 || wd !== 16'd0) begin
      miscompares++; $display("FAIL to_result: got err %b words %0d exp 1 0", e, wd);
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (avm_read !== 1'b0 || rd_cycles !== 1 || wr_cycles !== 0) begin
      miscompares++;
      $display("FAIL to_bus: got rd %b rd_cyc %0d wr_cyc %0d exp 0 1 0", avm_read, rd_cycles, wr_cycles);
    end
    no_resp = 1'b0;
    exp_q.delete(); exp_addr_q.delete();
  endtask

  task automatic test_wrap();
    int k; logic e, fb, bd; logic [15:0] wd; logic [31:0] a;
    prime(32'hFFFF_FFF8, 32'h0600, 3);
    do_start(32'hFFFF_FFF8, 32'h0600, 16'd3);
    wait_done(40, k, e, wd, fb, bd);
    vectors++;
    if (k !== 10 || e !== 1'b0 || wd !== 16'd3) begin
      miscompares++; $display("FAIL wrap_result: got k %0d err %b words %0d exp 10 0 3", k, e, wd);
    end
    a = 32'h0608;
    vectors++;
    if (mem[a[11:2]] !== PAT) begin
      miscompares++; $display("FAIL wrap_mem2: got %h exp %h", mem[a[11:2]], PAT);
    end
    a = 32'h0600;
    vectors++;
    if (mem[a[11:2]] !== (PAT ^ 32'hFFFF_FFF8)) begin
      miscompares++; $display("FAIL wrap_mem0: got %h exp %h", mem[a[11:2]], PAT ^ 32'hFFFF_FFF8);
    end
  endtask

  task automatic test_reset_mid();
    int k; logic e, fb, bd; logic [15:0] wd; logic [31:0] a; bit found;
    prime(32'h0400, 32'h0500, 4);
    do_start(32'h0400, 32'h0500, 16'd4);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (avm_write === 1'b1 && words_done === 16'd1) begin found = 1'b1; break; end
    end
    vectors++;
    if (!found) begin miscompares++; $display("FAIL rstmid_reach: got 0 exp 1"); end
    #1 reset = 1'b1;
    @(negedge clk);
    vectors++;
    if ({avm_read, avm_write, busy, done} !== 4'b0) begin
      miscompares++;
      $display("FAIL rstmid_bus: got %b exp 0000", {avm_read, avm_write, busy, done});
    end
    vectors++;
    if (words_done !== 16'd0 || dbg_state !== IDLE) begin
      miscompares++; $display("FAIL rstmid_state: got words %0d state %0d exp 0 0", words_done, dbg_state);
    end
    reset = 1'b0;
    prime(32'h0400, 32'h0580, 2);
    do_start(32'h0400, 32'h0580, 16'd2);
    wait_done(40, k, e, wd, fb, bd);
    vectors++;
    if (k !== 7 || e !== 1'b0 || wd !== 16'd2) begin
      miscompares++; $display("FAIL rstmid_copy: got k %0d err %b words %0d exp 7 0 2", k, e, wd);
    end
    for (int i = 0; i < 2; i++) begin
      a = 32'h0580 + 32'(4 * i);
      vectors++;
      if (mem[a[11:2]] !== (PAT ^ (32'h0400 + 32'(4 * i)))) begin
        miscompares++;
        $display("FAIL rstmid_mem%0d: got %h exp %h", i, mem[a[11:2]], PAT ^ (32'h0400 + 32'(4 * i)));
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    fork
      slave_loop();
    join_none
    reset = 1'b1;
    repeat (3) @(negedge clk);
    test_reset();
    reset = 1'b0;
    test_copy_basic();
    test_random_stall();
    test_misalign();
    test_len_zero();
    test_timeout();
    test_wrap();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
